// File: rtl/cla4_seq_adder.sv
// Multi-cycle W-bit adder built around a single 4-bit carry-lookahead slice.
// One nibble per cycle, LSB first; a carry register chains the slices.

module cla4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_c,
    output logic [3:0] o_s,
    output logic       o_co
);
    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [3:0] w_c;

    assign w_p = i_a ^ i_b;
    assign w_g = i_a & i_b;

    assign w_c[0] = i_c;
    assign w_c[1] = w_g[0] | (w_p[0] & i_c);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_c);
    assign o_co   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_c);

    assign o_s = w_p ^ w_c;
endmodule

// state | meaning
// IDLE  | waiting for start
// RUN   | one nibble per edge through the cla4 slice
// DONE  | one-cycle completion pulse; may accept the next start
module cla4_seq_adder #(
    parameter int N_NIBBLES = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [4*N_NIBBLES-1:0]   a,
    input  logic [4*N_NIBBLES-1:0]   b,
    input  logic                     ci,
    output logic                     busy,
    output logic                     done,
    output logic [4*N_NIBBLES-1:0]   s,
    output logic                     co
);
    localparam int W  = 4 * N_NIBBLES;
    localparam int CW = (N_NIBBLES > 1) ? $clog2(N_NIBBLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            w_accept;
    logic            w_last;
    logic [W-1:0]    r_a_sh;
    logic [W-1:0]    r_b_sh;
    logic            r_carry;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_s;
    logic            r_co;
    logic [3:0]      w_slice_s;
    logic            w_slice_co;
    logic [W-1:0]    w_s_next;

    cla4 u_cla4 (
        .i_a  (r_a_sh[3:0]),
        .i_b  (r_b_sh[3:0]),
        .i_c  (r_carry),
        .o_s  (w_slice_s),
        .o_co (w_slice_co)
    );

    assign w_last = (r_cnt == CW'(N_NIBBLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                    w_accept     = 1'b1;
                end
            end
            S_RUN: begin
                if (w_last) w_state_next = S_DONE;
            end
            S_DONE: begin
                if (start) begin
                    w_state_next = S_RUN;
                    w_accept     = 1'b1;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_s     <= '0;
            r_co    <= 1'b0;
        end else if (w_accept) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= ci;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_a_sh  <= r_a_sh >> 4;
            r_b_sh  <= r_b_sh >> 4;
            r_carry <= w_slice_co;
            if (w_last) begin
                r_s  <= w_s_next;
                r_co <= w_slice_co;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Only the N-1 earlier nibbles need storing; the current slice output completes the word.
    if (N_NIBBLES > 1) begin : g_ssh
        logic [W-5:0] r_s_sh;

        always_ff @(posedge clk or posedge reset) begin
            if (reset)                 r_s_sh <= '0;
            else if (r_state == S_RUN) r_s_sh <= w_s_next[W-1:4];
        end

        assign w_s_next = {w_slice_s, r_s_sh};
    end else begin : g_no_ssh
        assign w_s_next = w_slice_s;
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign s    = r_s;
    assign co   = r_co;
endmodule

// File: tb/tb_cla4_seq_adder.sv
// Bench for cla4_seq_adder: directed vector table, reset/back-to-back sequences,
// and random adds checked against plain a+b+ci arithmetic.

module tb_cla4_seq_adder;
    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        busy;
    logic        done;
    logic [31:0] s;
    logic        co;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int done_cyc = 0;
    logic [31:0] exp_last_s  = '0;
    logic        exp_last_co = 1'b0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic [31:0] s;
        logic        co;
    } vec_t;

    vec_t vecs[7];

    cla4_seq_adder #(.N_NIBBLES(8)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Starts an add at the current negedge, scrambles inputs while busy,
    // and checks result, latency and output behaviour at the done cycle.
    task automatic run_add(input logic [31:0] ta, input logic [31:0] tbv, input logic tci,
                           input logic [31:0] es, input logic ec, input bit hold_start,
                           input string nm);
        int lat;
        bit seen, overlap, hold_bad, busy_bad;
        a = ta; b = tbv; ci = tci; start = 1'b1;
        @(posedge clk);
        lat = 0; seen = 0; overlap = 0; hold_bad = 0; busy_bad = 0;
        while (!seen && lat <= 20) begin
            @(negedge clk);
            if (busy && done) overlap = 1;
            if (done) begin
                seen = 1;
            end else begin
                if (!busy) busy_bad = 1;
                if (s !== exp_last_s || co !== exp_last_co) hold_bad = 1;
                a  = $urandom;
                b  = $urandom;
                ci = 1'($urandom);
                start = hold_start ? 1'b1 : 1'($urandom_range(0, 1));
                @(posedge clk);
                lat++;
            end
        end
        start = hold_start ? 1'b1 : 1'b0;
        done_cyc = cyc;
        chk({nm, " done_seen"}, 64'(seen), 64'd1);
        chk({nm, " latency"}, 64'(lat), 64'd8);
        chk({nm, " s"}, 64'(s), 64'(es));
        chk({nm, " co"}, 64'(co), 64'(ec));
        chk({nm, " busy_while_run"}, 64'(busy_bad), 64'd0);
        chk({nm, " busy_done_overlap"}, 64'(overlap), 64'd0);
        chk({nm, " s_hold"}, 64'(hold_bad), 64'd0);
        exp_last_s  = es;
        exp_last_co = ec;
    endtask

    initial begin
        bit          bad;
        int          prev_cyc;
        logic [32:0] sum;
        logic [31:0] ra, rb;
        logic        rci;

        vecs[0] = '{32'h0000_0003, 32'h0000_0005, 1'b0, 32'h0000_0008, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
        vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
        vecs[4] = '{32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0};
        vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0};
        vecs[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};

        reset = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset s", 64'(s), 64'd0);
        chk("reset co", 64'(co), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_add(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].s, vecs[i].co, 1'b0,
                    $sformatf("vec%0d", i));
            repeat (2) @(negedge clk);
        end

        // Reset pulse after edge 3 of a run: outputs clear at once, no done follows.
        a = 32'h1111_1111; b = 32'h2222_2222; ci = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrun_reset busy", 64'(busy), 64'd0);
        chk("midrun_reset done", 64'(done), 64'd0);
        chk("midrun_reset s", 64'(s), 64'd0);
        chk("midrun_reset co", 64'(co), 64'd0);
        exp_last_s = '0; exp_last_co = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        repeat (15) begin
            @(negedge clk);
            if (done || busy) bad = 1;
        end
        chk("midrun_reset no_done", 64'(bad), 64'd0);
        run_add(32'h0000_0003, 32'h0000_0005, 1'b0, 32'h0000_0008, 1'b0, 1'b0, "post_reset");
        @(negedge clk);

        // Start held high: new operands presented in each DONE cycle.
        prev_cyc = 0;
        for (int i = 0; i < 5; i++) begin
            ra = $urandom; rb = $urandom; rci = 1'($urandom);
            sum = {1'b0, ra} + {1'b0, rb} + {32'd0, rci};
            run_add(ra, rb, rci, sum[31:0], sum[32], 1'b1, $sformatf("b2b%0d", i));
            if (i > 0) chk($sformatf("b2b%0d period", i), 64'(done_cyc - prev_cyc), 64'd9);
            prev_cyc = done_cyc;
        end
        start = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom; rb = $urandom; rci = 1'($urandom);
            if (i % 4 == 0) ra = 32'hFFFF_FFFF - rb;
            sum = {1'b0, ra} + {1'b0, rb} + {32'd0, rci};
            run_add(ra, rb, rci, sum[31:0], sum[32], 1'b0, $sformatf("rand%0d", i));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
